// File: rtl/timer_bank.sv
// Bank of 8051-style timer/counters with modes 0-3, gating, external pin counting, TH/TL byte writes.
// Counts land on machine-cycle ticks or synchronised t_pin falls; tf/ovf are registered with the count.
module timer_bank #(
    parameter int CH       = 2,
    parameter int PRESCALE = 12,
    parameter int AW       = $clog2(CH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4*CH-1:0] tmod,
    input  logic [CH-1:0]   tr,
    input  logic [CH-1:0]   t_pin,
    input  logic [CH-1:0]   int_pin,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [7:0]      wr_data,
    input  logic [CH-1:0]   tf_clr,
    output logic [8*CH-1:0] tl_o,
    output logic [8*CH-1:0] th_o,
    output logic [CH-1:0]   tf,
    output logic [CH-1:0]   ovf
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = AW - 1;

    logic [PW-1:0] pre_q, pre_d;
    logic          mc_tick;

    always_comb begin
        mc_tick = (pre_q == PW'(PRESCALE - 1));
        pre_d   = mc_tick ? '0 : pre_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [3:0]  md;
        logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
        logic        fall, run, tick, wr_hit;
        logic [7:0]  tl_q, tl_d, th_q, th_d;
        logic        tf_q, tf_d, ovf_q, ovf_d;
        logic [12:0] inc13;
        logic [15:0] inc16;

        assign md = tmod[4*g +: 4];

        always_comb begin
            s1_d   = t_pin[g];
            s2_d   = s1_q;
            s3_d   = s2_q;
            fall   = s3_q & ~s2_q;
            run    = tr[g] & (~md[3] | int_pin[g]);
            tick   = run & (md[2] ? fall : mc_tick);
            wr_hit = wr_en & (wr_addr[AW-1:1] == CW'(g));
            inc13  = {th_q, tl_q[4:0]} + 13'd1;
            inc16  = {th_q, tl_q} + 16'd1;

            tl_d   = tl_q;
            th_d   = th_q;
            ovf_d  = 1'b0;
            tf_d   = tf_q & ~tf_clr[g];

            // A CPU write owns the channel for its cycle: the tick is dropped entirely.
            if (wr_hit) begin
                if (wr_addr[0]) th_d = wr_data;
                else            tl_d = wr_data;
            end else if (tick) begin
                case (md[1:0])
                    2'd0: begin
                        {th_d, tl_d[4:0]} = inc13;
                        ovf_d             = &{th_q, tl_q[4:0]};
                    end
                    2'd1: begin
                        {th_d, tl_d} = inc16;
                        ovf_d        = &{th_q, tl_q};
                    end
                    2'd2: begin
                        if (&tl_q) begin
                            tl_d  = th_q;
                            ovf_d = 1'b1;
                        end else begin
                            tl_d = tl_q + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end

            if (ovf_d) tf_d = 1'b1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q  <= 1'b1;
                s2_q  <= 1'b1;
                s3_q  <= 1'b1;
                tl_q  <= 8'h00;
                th_q  <= 8'h00;
                tf_q  <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                s1_q  <= s1_d;
                s2_q  <= s2_d;
                s3_q  <= s3_d;
                tl_q  <= tl_d;
                th_q  <= th_d;
                tf_q  <= tf_d;
                ovf_q <= ovf_d;
            end
        end

        assign tl_o[8*g +: 8] = tl_q;
        assign th_o[8*g +: 8] = th_q;
        assign tf[g]          = tf_q;
        assign ovf[g]         = ovf_q;
    end
endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank (CH=2, PRESCALE=12) with hand-computed expectations.
module tb_timer_bank;
    logic        clk;
    logic        rst_n;
    logic [7:0]  tmod;
    logic [1:0]  tr;
    logic [1:0]  t_pin;
    logic [1:0]  int_pin;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  tf_clr;
    logic [15:0] tl_o;
    logic [15:0] th_o;
    logic [1:0]  tf;
    logic [1:0]  ovf;

    int n_vec = 0;
    int n_err = 0;
    int ecnt;

    timer_bank #(.CH(2), .PRESCALE(12), .AW(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tmod    (tmod),
        .tr      (tr),
        .t_pin   (t_pin),
        .int_pin (int_pin),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .tf_clr  (tf_clr),
        .tl_o    (tl_o),
        .th_o    (th_o),
        .tf      (tf),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_to(input int t);
        while (ecnt < t) @(negedge clk);
    endtask

    task automatic pulse0();
        t_pin[0] = 1'b0;
        repeat (4) @(negedge clk);
        t_pin[0] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b1;
        tmod    = 8'h21;
        tr      = 2'b00;
        t_pin   = 2'b11;
        int_pin = 2'b00;
        wr_en   = 1'b0;
        wr_addr = 2'b00;
        wr_data = 8'h00;
        tf_clr  = 2'b00;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tl", tl_o, 16'h0000);
        chk("rst_th", th_o, 16'h0000);
        chk("rst_flags", {14'd0, tf, ovf} & 16'hF, 16'h0000);

        // Mode 1 on ch0, writes in the first two cycles after release.
        rst_n = 1'b1; tr = 2'b01;
        wr_en = 1'b1; wr_addr = 2'b00; wr_data = 8'hFE;
        wait_to(1);  wr_addr = 2'b01; wr_data = 8'hFF;
        wait_to(2);  wr_en = 1'b0;
        chk("wr_lat_th0", {8'h00, th_o[7:0]}, 16'h00FF);
        wait_to(11); chk("m1_pre_tl0", {8'h00, tl_o[7:0]}, 16'h00FE);
        wait_to(12); chk("m1_tick1", {th_o[7:0], tl_o[7:0]}, 16'hFFFF);
        chk("m1_no_tf", {15'd0, tf[0]}, 16'h0000);
        wait_to(23); tf_clr = 2'b01;
        wait_to(24);
        chk("m1_wrap", {th_o[7:0], tl_o[7:0]}, 16'h0000);
        chk("m1_tf_setwins", {15'd0, tf[0]}, 16'h0001);
        chk("m1_ovf", {15'd0, ovf[0]}, 16'h0001);
        wait_to(25);
        chk("m1_ovf_1clk", {15'd0, ovf[0]}, 16'h0000);
        chk("m1_tf_clr", {15'd0, tf[0]}, 16'h0000);
        tf_clr = 2'b00;

        // Mode 2 on ch1.
        wr_en = 1'b1; wr_addr = 2'b11; wr_data = 8'h9C;
        wait_to(26); wr_addr = 2'b10; wr_data = 8'hFF; tr = 2'b11;
        wait_to(27); wr_en = 1'b0;
        wait_to(35); chk("m2_pre", {th_o[15:8], tl_o[15:8]}, 16'h9CFF);
        wait_to(36);
        chk("m2_reload", {th_o[15:8], tl_o[15:8]}, 16'h9C9C);
        chk("m2_tf_ovf", {14'd0, tf[1], ovf[1]}, 16'h0003);
        tf_clr = 2'b10;
        wait_to(37); tf_clr = 2'b00;
        chk("m2_tf_clr", {15'd0, tf[1]}, 16'h0000);
        wait_to(1224); chk("m2_99", {8'h00, tl_o[15:8]}, 16'h00FF);
        wait_to(1236);
        chk("m2_second", {8'h00, tl_o[15:8]}, 16'h009C);
        chk("m2_second_flags", {14'd0, tf[1], ovf[1]}, 16'h0003);

        // Mode 0 on ch0.
        tmod = 8'h20;
        wr_en = 1'b1; wr_addr = 2'b01; wr_data = 8'hFF;
        wait_to(1237); wr_addr = 2'b00; wr_data = 8'hBF;
        wait_to(1238); wr_en = 1'b0;
        wait_to(1248);
        chk("m0_wrap", {th_o[7:0], tl_o[7:0]}, 16'h00A0);
        chk("m0_flags", {14'd0, tf[0], ovf[0]}, 16'h0003);

        // Write colliding with an overflowing tick.
        wr_en = 1'b1; wr_addr = 2'b01; wr_data = 8'hFF;
        wait_to(1249); wr_addr = 2'b00; wr_data = 8'h1F; tf_clr = 2'b01;
        wait_to(1250); wr_en = 1'b0; tf_clr = 2'b00;
        chk("m0_tf_cleared", {15'd0, tf[0]}, 16'h0000);
        wait_to(1259); wr_en = 1'b1; wr_addr = 2'b00; wr_data = 8'h55;
        wait_to(1260); wr_en = 1'b0;
        chk("wr_col_data", {th_o[7:0], tl_o[7:0]}, 16'hFF55);
        chk("wr_col_noovf", {14'd0, tf[0], ovf[0]}, 16'h0000);
        wait_to(1272);
        chk("m0_resume", {th_o[7:0], tl_o[7:0]}, 16'hFF56);

        // Gated counter on ch0: gate closed, then open.
        tmod = 8'h2D; int_pin = 2'b00;
        for (int i = 0; i < 5; i++) pulse0();
        chk("gate_hold", {th_o[7:0], tl_o[7:0]}, 16'hFF56);
        int_pin = 2'b01;
        t_pin[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("pin_lat_e1", {8'h00, tl_o[7:0]}, 16'h0056);
        @(negedge clk);
        chk("pin_lat_e2", {8'h00, tl_o[7:0]}, 16'h0057);
        @(negedge clk);
        t_pin[0] = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) pulse0();
        chk("gate_open_cnt", {th_o[7:0], tl_o[7:0]}, 16'hFF5B);

        // Asynchronous reset mid-count.
        tmod = 8'h21; int_pin = 2'b00;
        wr_en = 1'b1; wr_addr = 2'b00; wr_data = 8'h37;
        @(negedge clk); wr_en = 1'b0;
        chk("rst_pre_tl0", {8'h00, tl_o[7:0]}, 16'h0037);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tl", tl_o, 16'h0000);
        chk("arst_th", th_o, 16'h0000);
        chk("arst_flags", {12'd0, tf, ovf}, 16'h0000);
        @(negedge clk); rst_n = 1'b1;
        wait_to(11); chk("rel_pre", {8'h00, tl_o[7:0]}, 16'h0000);
        wait_to(12); chk("rel_first", {th_o[7:0], tl_o[7:0]}, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
